// File: rtl/bytecode_pkg.sv
// Shared constants and state encoding for the bytecode machine sequencer.
package bytecode_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_OP_W   = 6;

    localparam logic [7:0] OPC_UNARY  = 8'h01;
    localparam logic [7:0] OPC_BINARY = 8'h02;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_OPC,
        S_F_OP,
        S_F_A,
        S_F_B,
        S_EXEC,
        S_HALT,
        S_ERR
    } state_t;

endpackage

// File: rtl/bytecode_sequencer.sv
// Fetch/decode/execute controller: pulls bytecode bytes over a req/valid
// handshake, loads ALU op/operand registers and captures the ALU result.
module bytecode_sequencer
    import bytecode_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              running,
    output logic              halted,
    output logic              error
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_mem_req;
    logic                r_binary;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_valid;
    logic                r_running;
    logic                r_halted;
    logic                r_error;

    logic                w_capture;

    // A byte is taken only while a request is outstanding.
    assign w_capture = r_mem_req && mem_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_mem_req      <= 1'b0;
            r_binary       <= 1'b0;
            r_alu_op       <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_running      <= 1'b0;
            r_halted       <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (start) begin
                        r_state   <= S_F_OPC;
                        r_pc      <= '0;
                        r_mem_req <= 1'b1;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                        r_error   <= 1'b0;
                    end
                end
                S_F_OPC: begin
                    if (w_capture) begin
                        r_pc <= r_pc + ADDR_W'(1);
                        if (mem_rdata == DATA_W'(OPC_UNARY) ||
                            mem_rdata == DATA_W'(OPC_BINARY)) begin
                            r_binary <= (mem_rdata == DATA_W'(OPC_BINARY));
                            r_state  <= S_F_OP;
                        end else if (mem_rdata == DATA_W'(OPC_HALT)) begin
                            r_state   <= S_HALT;
                            r_mem_req <= 1'b0;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end else begin
                            r_state   <= S_ERR;
                            r_mem_req <= 1'b0;
                            r_running <= 1'b0;
                            r_error   <= 1'b1;
                        end
                    end
                end
                S_F_OP: begin
                    if (w_capture) begin
                        r_pc     <= r_pc + ADDR_W'(1);
                        r_alu_op <= mem_rdata[OP_W-1:0];
                        r_state  <= S_F_A;
                    end
                end
                S_F_A: begin
                    if (w_capture) begin
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_alu_a <= mem_rdata;
                        if (r_binary) begin
                            r_state <= S_F_B;
                        end else begin
                            r_alu_b   <= '0;
                            r_state   <= S_EXEC;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                S_F_B: begin
                    if (w_capture) begin
                        r_pc      <= r_pc + ADDR_W'(1);
                        r_alu_b   <= mem_rdata;
                        r_state   <= S_EXEC;
                        r_mem_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_result       <= alu_result;
                    r_result_valid <= 1'b1;
                    r_state        <= S_F_OPC;
                    r_mem_req      <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_pc;
    assign alu_op       = r_alu_op;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign running      = r_running;
    assign halted       = r_halted;
    assign error        = r_error;

endmodule
